// File: rtl/dcache_inv_queue.sv
// rtl/dcache_inv_queue.sv - dcache external (snoop) invalidation queue
//
// Buffers bus-snoop line invalidations in a DEPTH-entry circular FIFO and
// presents them one at a time to the dcache tag banks.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inv_req, inv_req_addr incoming invalidation request and its byte address
//   extern_inv, inv_addr  presented invalidation and its line address
//   extern_inv_complete   tag banks finished the presented invalidation
//   inv_full, inv_count   occupancy status
//   inv_overflow          sticky: a non-duplicate request was lost
module dcache_inv_queue #(
  parameter int DEPTH    = 4,
  parameter int LINE_LSB = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inv_req,
  input  logic [31:0]              inv_req_addr,
  output logic                     extern_inv,
  output logic [31:0]              inv_addr,
  input  logic                     extern_inv_complete,
  output logic                     inv_full,
  output logic [$clog2(DEPTH):0]   inv_count,
  output logic                     inv_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = 32 - LINE_LSB;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow_q;

  logic [TAG_W-1:0] req_line;
  logic             pop;
  logic             push;
  logic             dup;
  logic             full;
  logic             unused_low_bits;

  assign req_line        = inv_req_addr[31:LINE_LSB];
  assign unused_low_bits = ^inv_req_addr[LINE_LSB-1:0];

  assign full = (count == CNT_W'(DEPTH));
  // A completion with nothing presented is ignored.
  assign pop  = (count != '0) && extern_inv_complete;

  // Compare against every occupied slot, walking from head. The head is
  // excluded when it retires this cycle, so a fresh snoop to that same line
  // is queued again rather than lost.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && !(pop && (i == 0)) &&
          (mem[head + PTR_W'(i)] == req_line)) begin
        dup = 1'b1;
      end
    end
  end

  assign push = inv_req && !dup && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (inv_req && !dup && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Entry storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= req_line;
  end

  assign extern_inv   = (count != '0);
  assign inv_addr     = {mem[head], {LINE_LSB{1'b0}}};
  assign inv_full     = full;
  assign inv_count    = count;
  assign inv_overflow = overflow_q;

endmodule

// File: tb/tb_dcache_inv_queue.sv
// tb/tb_dcache_inv_queue.sv - self-checking bench for dcache_inv_queue
module tb_dcache_inv_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv_req = 1'b0;
  logic [31:0] inv_req_addr = 32'h0;
  logic        extern_inv;
  logic [31:0] inv_addr;
  logic        extern_inv_complete = 1'b0;
  logic        inv_full;
  logic [2:0]  inv_count;
  logic        inv_overflow;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic [27:0] exp_q[$];
  bit          exp_ovf = 0;

  always #5 clk = ~clk;

  dcache_inv_queue #(.DEPTH(4), .LINE_LSB(4)) dut (
    .clk(clk),
    .rst(rst),
    .inv_req(inv_req),
    .inv_req_addr(inv_req_addr),
    .extern_inv(extern_inv),
    .inv_addr(inv_addr),
    .extern_inv_complete(extern_inv_complete),
    .inv_full(inv_full),
    .inv_count(inv_count),
    .inv_overflow(inv_overflow)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // One clock of stimulus; the reference queue predicts pushes/pops and
  // checks each presented entry as it retires.
  task automatic step(input logic r, input logic [31:0] a, input logic c);
    logic [27:0] line;
    bit pop_m, dup_m, push_m;
    line  = a[31:4];
    pop_m = c && (exp_q.size() != 0);
    dup_m = 0;
    for (int j = (pop_m ? 1 : 0); j < exp_q.size(); j++)
      if (exp_q[j] == line) dup_m = 1;
    push_m = r && !dup_m && ((exp_q.size() < 4) || pop_m);
    if (r && !dup_m && exp_q.size() == 4 && !pop_m) exp_ovf = 1;
    if (pop_m) begin
      tests++;
      pops++;
      if (extern_inv !== 1'b1 || inv_addr !== {exp_q[0], 4'h0}) begin
        fails++;
        $display("FAIL pop_order: extern_inv=%b inv_addr=%h, required extern_inv=1 inv_addr=%h",
                 extern_inv, inv_addr, {exp_q[0], 4'h0});
      end
    end
    inv_req = r;
    inv_req_addr = a;
    extern_inv_complete = c;
    @(posedge clk);
    #1;
    inv_req = 1'b0;
    extern_inv_complete = 1'b0;
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) exp_q.push_back(line);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
  endtask

  task automatic test_reset();
    tests++;
    if (extern_inv !== 1'b0 || inv_count !== 3'd0 || inv_full !== 1'b0 || inv_overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: extern_inv=%b count=%0d full=%b ovf=%b, required 0/0/0/0",
               extern_inv, inv_count, inv_full, inv_overflow);
    end
  endtask

  task automatic test_single_push();
    step(1, 32'h0000_1234, 0);
    tests++;
    if (extern_inv !== 1'b1 || inv_addr !== 32'h0000_1230 || inv_count !== 3'd1) begin
      fails++;
      $display("FAIL single_push: extern_inv=%b addr=%h count=%0d, required 1 00001230 1",
               extern_inv, inv_addr, inv_count);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0);
      tests++;
      if (inv_addr !== 32'h0000_1230 || extern_inv !== 1'b1) begin
        fails++;
        $display("FAIL hold_stable: addr=%h extern_inv=%b, required 00001230 1", inv_addr, extern_inv);
      end
    end
    step(0, 0, 1);
    tests++;
    if (extern_inv !== 1'b0 || inv_count !== 3'd0) begin
      fails++;
      $display("FAIL single_drain: extern_inv=%b count=%0d, required 0 0", extern_inv, inv_count);
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    step(1, 32'h100, 0);
    step(1, 32'h204, 0);
    step(1, 32'h100, 0);
    tests++;
    if (inv_count !== 3'd2 || inv_overflow !== 1'b0 || inv_addr !== 32'h100) begin
      fails++;
      $display("FAIL dup_drop: count=%0d ovf=%b addr=%h, required 2 0 00000100",
               inv_count, inv_overflow, inv_addr);
    end
    step(0, 0, 1);
    tests++;
    if (inv_addr !== 32'h200) begin
      fails++;
      $display("FAIL dup_second: addr=%h, required 00000200", inv_addr);
    end
    step(0, 0, 1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, 32'(k * 16), 0);
    step(1, 32'h50, 0);
    tests++;
    if (inv_count !== 3'd4 || inv_full !== 1'b1 || inv_overflow !== 1'b1 || exp_ovf != 1) begin
      fails++;
      $display("FAIL overflow_drop: count=%0d full=%b ovf=%b, required 4 1 1",
               inv_count, inv_full, inv_overflow);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 1);
    tests++;
    if (inv_overflow !== 1'b1 || inv_count !== 3'd0) begin
      fails++;
      $display("FAIL overflow_sticky: ovf=%b count=%0d, required 1 0", inv_overflow, inv_count);
    end
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, 32'(k * 16), 0);
    step(1, 32'h50, 1);
    tests++;
    if (inv_count !== 3'd4 || inv_full !== 1'b1 || inv_overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_push_pop: count=%0d full=%b ovf=%b, required 4 1 0",
               inv_count, inv_full, inv_overflow);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 1);
  endtask

  task automatic test_reenqueue();
    do_reset();
    step(1, 32'h10, 0);
    step(1, 32'h10, 1);
    tests++;
    if (inv_count !== 3'd1 || extern_inv !== 1'b1 || inv_addr !== 32'h10) begin
      fails++;
      $display("FAIL reenqueue: count=%0d extern_inv=%b addr=%h, required 1 1 00000010",
               inv_count, extern_inv, inv_addr);
    end
    step(0, 0, 1);
  endtask

  task automatic test_back_to_back();
    int start_pops;
    do_reset();
    start_pops = pops;
    step(1, 32'h1000, 0);
    step(1, 32'h1010, 0);
    for (int k = 2; k < 10; k++) step(1, 32'h1000 + 32'(k * 16), 1);
    step(0, 0, 1);
    step(0, 0, 1);
    tests++;
    if (pops - start_pops != 10 || inv_count !== 3'd0 || extern_inv !== 1'b0) begin
      fails++;
      $display("FAIL wrap_drain: pops=%0d count=%0d extern_inv=%b, required 10 0 0",
               pops - start_pops, inv_count, extern_inv);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 3; k++) step(1, 32'(k * 256), 0);
    do_reset();
    tests++;
    if (inv_count !== 3'd0 || extern_inv !== 1'b0 || inv_overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: count=%0d extern_inv=%b ovf=%b, required 0 0 0",
               inv_count, extern_inv, inv_overflow);
    end
    step(1, 32'h0000_1234, 0);
    tests++;
    if (extern_inv !== 1'b1 || inv_addr !== 32'h0000_1230 || inv_count !== 3'd1) begin
      fails++;
      $display("FAIL post_reset_push: extern_inv=%b addr=%h count=%0d, required 1 00001230 1",
               extern_inv, inv_addr, inv_count);
    end
    step(0, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_push();
    test_duplicate();
    test_overflow();
    test_reenqueue();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_inv_queue.md
DCACHE_INV_QUEUE -- requirements
Module: dcache_inv_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning invalidation queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter LINE_LSB, default 4, meaning number of low address bits below line granularity (2 + sub-line address width).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous, active-high.
REQ-005 The block SHALL have port inv_req, input, 1 bit, meaning external (bus snoop) invalidation request this cycle.
REQ-006 The block SHALL have port inv_req_addr, input, 32 bits, meaning byte address of the line to invalidate.
REQ-007 The block SHALL have port extern_inv, output, 1 bit, meaning invalidation presented to the dcache tag banks.
REQ-008 The block SHALL have port inv_addr, output, 32 bits, meaning line address of the presented invalidation, bits [LINE_LSB-1:0] zero.
REQ-009 The block SHALL have port extern_inv_complete, input, 1 bit, meaning the tag banks finished the presented invalidation.
REQ-010 The block SHALL have port inv_full, output, 1 bit, meaning all DEPTH entries occupied.
REQ-011 The block SHALL have port inv_count, output, $clog2(DEPTH)+1 bits, meaning occupied entries.
REQ-012 The block SHALL have port inv_overflow, output, 1 bit, meaning sticky flag: a non-duplicate request was lost.

Function
REQ-013 Storage SHALL be a circular FIFO of DEPTH entries holding inv_req_addr[31:LINE_LSB], with head/tail pointers wrapping modulo DEPTH.
REQ-014 extern_inv SHALL equal (inv_count != 0), driven from registered state only, never combinationally from inv_req.
REQ-015 inv_addr SHALL be {head entry, LINE_LSB'b0} and remain stable while extern_inv=1 and extern_inv_complete=0.
REQ-016 pop SHALL occur when extern_inv & extern_inv_complete; extern_inv_complete while extern_inv=0 SHALL be ignored.
REQ-017 dup SHALL be true when inv_req_addr[31:LINE_LSB] equals any occupied entry, excluding the head when pop occurs that cycle.
REQ-018 push SHALL occur when inv_req & ~dup & (~inv_full | pop); push and pop in the same cycle leave inv_count unchanged.
REQ-019 A duplicate request SHALL be dropped silently with no state change.
REQ-020 inv_overflow SHALL set when inv_req & ~dup & inv_full & ~pop, and stay set until reset.
REQ-021 Push into an empty queue SHALL raise extern_inv on the following cycle (1-cycle latency).
REQ-022 Entries SHALL be presented strictly in push order; inv_full SHALL equal (inv_count == DEPTH).

Reset
REQ-023 On rst, inv_count, head and tail pointers SHALL be 0, extern_inv=0, inv_full=0, inv_overflow=0; inv_addr is don't-care while extern_inv=0.
REQ-024 rst asserted mid-invalidation SHALL discard all queued entries; extern_inv SHALL be 0 in the cycle after rst is sampled high.
REQ-025 Entry storage SHALL NOT require reset.

Verification
REQ-026 Push 0x0000_1234 into empty queue -> next cycle extern_inv=1, inv_addr=0x0000_1230, inv_count=1; complete held 0 for 5 cycles -> inv_addr stable.
REQ-027 Push 0x100, 0x204, 0x100 (DEPTH=4) -> inv_count=2; pops present 0x100 then 0x200; inv_overflow=0.
REQ-028 Fill with 0x10,0x20,0x30,0x40, push 0x50 without pop -> dropped, inv_overflow=1, inv_count=4; same case with concurrent complete -> 0x50 accepted, inv_count=4, inv_overflow=0.
REQ-029 Head 0x10 completing while inv_req=0x10 -> 0x10 re-enqueued, inv_count unchanged at 1, extern_inv stays 1.
REQ-030 Push/pop 10 distinct lines through DEPTH=4 -> pointer wrap, all 10 presented in order, inv_count returns to 0, extern_inv=0.
REQ-031 Queue holding 3 entries, assert rst one cycle -> inv_count=0, extern_inv=0, inv_overflow=0; next push behaves as REQ-026.
